// File: rtl/undo_stack.sv
// LIFO history buffer: push displaced values, pop them back on reverse execution, peek by offset.
// Optional checkpoint/rewind support is enabled with `define UNDO_STACK_CHECKPOINT_EN.
module undo_stack #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned OFF_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push_en,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop_en,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  pop_valid,
  input  logic                  peek_en,
  input  logic [OFF_BITS-1:0]   peek_off,
  output logic [WIDTH-1:0]      peek_data,
  output logic                  peek_valid,
`ifdef UNDO_STACK_CHECKPOINT_EN
  input  logic                  mark,
  input  logic                  rewind,
  output logic [DEPTH_LOG2:0]   cp_depth,
`endif
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] sp_q, sp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      pop_data_q, pop_data_d;
  logic [WIDTH-1:0]      peek_data_q, peek_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  peek_valid_q, peek_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [DEPTH_LOG2-1:0] peek_idx;
  logic                  is_empty;
  logic                  is_full;
  logic                  rewind_act;

  assign top_idx  = sp_q - DEPTH_LOG2'(1);
  assign peek_idx = sp_q - DEPTH_LOG2'(peek_off) - DEPTH_LOG2'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

`ifdef UNDO_STACK_CHECKPOINT_EN
  logic [DEPTH_LOG2-1:0] cp_sp_q, cp_sp_d;
  logic [CW-1:0]         cp_count_q, cp_count_d;

  assign rewind_act = rewind;
  assign cp_depth   = (count_q >= cp_count_q) ? (count_q - cp_count_q) : '0;

  always_comb begin
    cp_sp_d    = cp_sp_q;
    cp_count_d = cp_count_q;
    if (clear) begin
      cp_sp_d    = '0;
      cp_count_d = '0;
    end else if (mark && !rewind && !push_en && !pop_en) begin
      cp_sp_d    = sp_q;
      cp_count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cp_sp_q    <= '0;
      cp_count_q <= '0;
    end else begin
      cp_sp_q    <= cp_sp_d;
      cp_count_q <= cp_count_d;
    end
  end
`else
  assign rewind_act = 1'b0;
`endif

  always_comb begin
    sp_d         = sp_q;
    count_d      = count_q;
    pop_data_d   = pop_data_q;
    peek_data_d  = peek_data_q;
    pop_valid_d  = 1'b0;
    peek_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = sp_q;

    if (clear) begin
      sp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (rewind_act) begin
`ifdef UNDO_STACK_CHECKPOINT_EN
      sp_d    = cp_sp_q;
      count_d = (cp_count_q < count_q) ? cp_count_q : count_q;
`endif
    end else if (push_en && pop_en && !is_empty) begin
      // Replace-top: old top leaves through pop_data, new value takes its slot.
      pop_data_d  = mem[top_idx];
      pop_valid_d = 1'b1;
      mem_we      = 1'b1;
      mem_waddr   = top_idx;
    end else if (pop_en && !push_en && !is_empty) begin
      pop_data_d  = mem[top_idx];
      pop_valid_d = 1'b1;
      sp_d        = top_idx;
      count_d     = count_q - CW'(1);
    end else begin
      underflow_d = pop_en;
      if (push_en) begin
        mem_we = 1'b1;
        sp_d   = sp_q + DEPTH_LOG2'(1);
        if (is_full) overflow_d = 1'b1;
        else         count_d    = count_q + CW'(1);
      end
    end

    // Reads the pre-update array, so a same-cycle push is never visible.
    if (!clear && peek_en && (CW'(peek_off) < count_q)) begin
      peek_data_d  = mem[peek_idx];
      peek_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q         <= '0;
      count_q      <= '0;
      pop_data_q   <= '0;
      peek_data_q  <= '0;
      pop_valid_q  <= 1'b0;
      peek_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      sp_q         <= sp_d;
      count_q      <= count_d;
      pop_data_q   <= pop_data_d;
      peek_data_q  <= peek_data_d;
      pop_valid_q  <= pop_valid_d;
      peek_valid_q <= peek_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign pop_data   = pop_data_q;
  assign pop_valid  = pop_valid_q;
  assign peek_data  = peek_data_q;
  assign peek_valid = peek_valid_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_undo_stack.sv
// Directed bench for undo_stack: push/pop order, overflow/underflow, peek, replace-top, clear,
// async reset, and checkpoint/rewind when UNDO_STACK_CHECKPOINT_EN is defined.
module tb_undo_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        push_en;
  logic [15:0] push_data;
  logic        pop_en;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        peek_en;
  logic [3:0]  peek_off;
  logic [15:0] peek_data;
  logic        peek_valid;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef UNDO_STACK_CHECKPOINT_EN
  logic        mark;
  logic        rewind;
  logic [4:0]  cp_depth;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  undo_stack dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push_en    (push_en),
    .push_data  (push_data),
    .pop_en     (pop_en),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .peek_en    (peek_en),
    .peek_off   (peek_off),
    .peek_data  (peek_data),
    .peek_valid (peek_valid),
`ifdef UNDO_STACK_CHECKPOINT_EN
    .mark       (mark),
    .rewind     (rewind),
    .cp_depth   (cp_depth),
`endif
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push_en = 1'b0; push_data = '0; pop_en = 1'b0;
    peek_en = 1'b0; peek_off = '0;
`ifdef UNDO_STACK_CHECKPOINT_EN
    mark = 1'b0; rewind = 1'b0;
`endif
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    #9 reset = 1'b0;

    // Basic LIFO order
    push_en = 1'b1;
    push_data = 16'h1111; tick();
    push_data = 16'h2222; tick();
    push_data = 16'h3333; tick();
    push_en = 1'b0;
    chk("push3_count", 32'(count), 32'd3);
    pop_en = 1'b1;
    tick();
    chk("pop1_valid", 32'(pop_valid), 32'd1);
    chk("pop1_data", 32'(pop_data), 32'h3333);
    chk("pop1_count", 32'(count), 32'd2);
    tick();
    chk("pop2_data", 32'(pop_data), 32'h2222);
    tick();
    chk("pop3_data", 32'(pop_data), 32'h1111);
    pop_en = 1'b0;
    tick();
    chk("pop_valid_drop", 32'(pop_valid), 32'd0);
    chk("empty_after_pops", 32'(empty), 32'd1);

    // Overflow: 17 pushes into 16 slots, oldest (0) lost
    push_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_data = 16'(i);
      tick();
    end
    push_en = 1'b0;
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    pop_en = 1'b1;
    for (int i = 16; i >= 1; i--) begin
      tick();
      chk("ovf_pop_data", 32'(pop_data), 32'(i));
      chk("ovf_pop_valid", 32'(pop_valid), 32'd1);
    end
    tick();
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_pop_valid", 32'(pop_valid), 32'd0);
    chk("udf_pop_data_hold", 32'(pop_data), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    pop_en = 1'b0;
    tick();
    chk("udf_pulse_end", 32'(underflow), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Peek
    push_en = 1'b1;
    push_data = 16'hAAAA; tick();
    push_data = 16'hBBBB; tick();
    push_en = 1'b0;
    peek_en = 1'b1; peek_off = 4'd0;
    tick();
    chk("peek0_data", 32'(peek_data), 32'hBBBB);
    chk("peek0_valid", 32'(peek_valid), 32'd1);
    peek_off = 4'd1;
    tick();
    chk("peek1_data", 32'(peek_data), 32'hAAAA);
    peek_off = 4'd2;
    tick();
    chk("peek2_valid", 32'(peek_valid), 32'd0);
    chk("peek2_hold", 32'(peek_data), 32'hAAAA);
    peek_off = 4'd0; push_en = 1'b1; push_data = 16'hCCCC;
    tick();
    push_en = 1'b0; peek_en = 1'b0;
    chk("peek_rbw_data", 32'(peek_data), 32'hBBBB);
    chk("peek_rbw_count", 32'(count), 32'd3);
    tick();
    chk("peek_valid_drop", 32'(peek_valid), 32'd0);

    // Replace-top
    pop_en = 1'b1;
    tick();
    chk("pop_cccc", 32'(pop_data), 32'hCCCC);
    push_en = 1'b1; push_data = 16'hDDDD;
    tick();
    push_en = 1'b0;
    chk("rt_pop_data", 32'(pop_data), 32'hBBBB);
    chk("rt_count", 32'(count), 32'd2);
    tick();
    chk("rt_next_pop", 32'(pop_data), 32'hDDDD);
    tick();
    chk("rt_last_pop", 32'(pop_data), 32'hAAAA);
    pop_en = 1'b0;
    tick();

    // Clear after five pushes
    push_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = 16'h5000 + 16'(i);
      tick();
    end
    push_en = 1'b0;
    chk("pre_clear_count", 32'(count), 32'd5);
    clear = 1'b1; pop_en = 1'b1;
    tick();
    clear = 1'b0; pop_en = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_empty", 32'(empty), 32'd1);
    chk("clear_pop_valid", 32'(pop_valid), 32'd0);

    // Asynchronous reset between edges
    push_en = 1'b1;
    push_data = 16'h0E01; tick();
    push_data = 16'h0E02; tick();
    push_en = 1'b0; pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    chk("pre_arst_valid", 32'(pop_valid), 32'd1);
    chk("pre_arst_count", 32'(count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pop_valid", 32'(pop_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pop_data", 32'(pop_data), 32'd0);
    #3 reset = 1'b0;
    tick();
    chk("post_arst_empty", 32'(empty), 32'd1);

`ifdef UNDO_STACK_CHECKPOINT_EN
    push_en = 1'b1;
    push_data = 16'h0101; tick();
    push_data = 16'h0202; tick();
    push_en = 1'b0; mark = 1'b1;
    tick();
    mark = 1'b0; push_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = 16'h0300 + 16'(i);
      tick();
    end
    push_en = 1'b0;
    chk("cp_count5", 32'(count), 32'd5);
    chk("cp_depth3", 32'(cp_depth), 32'd3);
    rewind = 1'b1; pop_en = 1'b1;
    tick();
    rewind = 1'b0;
    chk("rewind_count", 32'(count), 32'd2);
    chk("rewind_pop_valid", 32'(pop_valid), 32'd0);
    tick();
    pop_en = 1'b0;
    chk("rewind_pop_data", 32'(pop_data), 32'h0202);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
